// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial BCD adder/subtractor, LSD first,
// one decimal digit per clock with valid/ready on both sides.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  error
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic            bad;
  logic [3:0]      bd;
  logic [4:0]      t;
  logic [4:0]      t6;
  logic            gt;
  logic [3:0]      dig;

  // Digit slice: nines-complement B in sub mode, then decimal correction.
  always_comb begin
    bd  = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    t   = {1'b0, a_q[3:0]} + {1'b0, bd} + {4'd0, carry_q};
    t6  = t + 5'd6;
    gt  = (t > 5'd9);
    dig = gt ? t6[3:0] : t[3:0];
  end

  // Flag any non-decimal digit on the incoming operands.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          if (bad) begin
            err_d   = 1'b1;
            sum_d   = '0;
            cout_d  = 1'b0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        sum_d          = sum_q >> 4;
        sum_d[W-1 -: 4] = dig;
        a_d            = a_q >> 4;
        b_d            = b_q >> 4;
        carry_d        = gt;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          cout_d  = sub_q ? ~gt : gt;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign error     = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: random and directed checks of the serial BCD
// adder against an integer-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         error;

  int errs = 0;
  int checks = 0;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint to_int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic cv, input int hold);
    longint p, r;
    logic [W-1:0] es;
    logic ec, ee;
    int lat;
    p = 1;
    for (int i = 0; i < D; i++) p = p * 10;
    ee = has_bad(av) || has_bad(bv);
    if (ee) begin
      es = '0;
      ec = 1'b0;
    end else if (!sv) begin
      r  = to_int(av) + to_int(bv) + longint'(cv);
      ec = (r >= p);
      es = to_bcd(r % p);
    end else begin
      r  = to_int(av) - to_int(bv) - longint'(cv);
      ec = (r < 0);
      es = to_bcd(r < 0 ? r + p : r);
    end
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    a = av; b = bv; sub = sv; cin = cv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3 * D) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid", out_valid, 1);
    chk("latency", lat, ee ? 0 : D);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("error", error, ee);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = (k == 1);
      a = W'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_sum", sum, es);
      chk("hold_cout", cout, ec);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
    chk("release_sum", sum, es);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    run_op(16'h0100, 16'h0001, 1'b1, 1'b0, 0);
    run_op(16'h0001, 16'h0002, 1'b1, 1'b0, 0);
    run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, 0);
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 0);
    run_op(16'h2468, 16'h1357, 1'b1, 1'b1, 5);
    run_op(16'h0000, 16'h9999, 1'b1, 1'b1, 0);

    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      ra = '0;
      rb = '0;
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0)
        ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 11) == 0)
        rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
